cnn_frame_scheduler: RTL and testbench



---
 rtl/cnn_frame_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_cnn_frame_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_scheduler.sv
// cnn_frame_scheduler: frame-level controller for the CNN inference pipeline.
// Launches one image through the fmap feeder and waits for the stage-3
// classification. It captures alpha/led and reports busy, done and error status.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   i_start, i_abort    frame request (sampled in IDLE/ERROR), abort to IDLE
//   i_sel[3:0]          image select, latched on launch into o_sel
//   i_core_valid        stage-1 conv output strobe
//   i_pool_valid        pooling output strobe
//   i_result_valid      classification valid, with i_alpha[7:0] and i_led[2:0]
//   o_feed_valid        one-cycle launch pulse to the feeder
//   o_sel[3:0]          latched image select
//   o_busy, o_done      frame in flight, one-cycle completion pulse
//   o_alpha, o_led      last captured classification
//   o_err, o_err_code   error flag; 01 = timeout, 10 = strobe count mismatch
//   o_frame_cnt[7:0]    completed frames, wrapping
//
// Optional feature: define CNN_SCHED_COUNT_CHECK_EN to build the conv and pool
// strobe counters. The result is then checked against CONV_OUT_CNT/POOL_OUT_CNT.
module cnn_frame_scheduler #(
    parameter int unsigned CONV_OUT_CNT = 576,
    parameter int unsigned POOL_OUT_CNT = 144,
    parameter int unsigned TIMEOUT      = 20000,
    parameter int unsigned CNT_BW       = 10,
    parameter int unsigned TO_BW        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [3:0] i_sel,
    input  logic       i_core_valid,
    input  logic       i_pool_valid,
    input  logic       i_result_valid,
    input  logic [7:0] i_alpha,
    input  logic [2:0] i_led,
    output logic       o_feed_valid,
    output logic [3:0] o_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_alpha,
    output logic [2:0] o_led,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic [7:0] o_frame_cnt
);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_COUNT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic               feed_valid_q, feed_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         alpha_q, alpha_d;
    logic [2:0]         led_q, led_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [TO_BW-1:0]   to_cnt_q, to_cnt_d;

    // Timeout terminal count: the cycle the counter holds TIMEOUT-1.
    logic to_term_c;
    assign to_term_c = (to_cnt_q == TO_BW'(TIMEOUT - 1));

`ifdef CNN_SCHED_COUNT_CHECK_EN
    logic [CNT_BW-1:0] conv_cnt_q, conv_cnt_d;
    logic [CNT_BW-1:0] pool_cnt_q, pool_cnt_d;
    logic              cnt_mismatch_c;

    // Evaluated on the result cycle, so it includes any strobe arriving with the result.
    assign cnt_mismatch_c = (conv_cnt_d != CNT_BW'(CONV_OUT_CNT)) ||
                            (pool_cnt_d != CNT_BW'(POOL_OUT_CNT));

    // Saturating strobe counters; active only in RUN, cleared on launch.
    always_comb begin
        conv_cnt_d = conv_cnt_q;
        pool_cnt_d = pool_cnt_q;
        if (!i_abort) begin
            if (state_q == S_IDLE && i_start) begin
                conv_cnt_d = '0;
                pool_cnt_d = '0;
            end else if (state_q == S_RUN) begin
                if (i_core_valid && (conv_cnt_q != '1)) begin
                    conv_cnt_d = conv_cnt_q + CNT_BW'(1);
                end
                if (i_pool_valid && (pool_cnt_q != '1)) begin
                    pool_cnt_d = pool_cnt_q + CNT_BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            conv_cnt_q <= '0;
            pool_cnt_q <= '0;
        end else begin
            conv_cnt_q <= conv_cnt_d;
            pool_cnt_q <= pool_cnt_d;
        end
    end
`else
    // Strobe inputs and count parameters have no function without the count check.
    logic unused_c;
    assign unused_c = ^{i_core_valid, i_pool_valid,
                        CNT_BW'(CONV_OUT_CNT), CNT_BW'(POOL_OUT_CNT)};
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        feed_valid_d = 1'b0;
        done_d       = 1'b0;
        alpha_d      = alpha_q;
        led_d        = led_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        frame_cnt_d  = frame_cnt_q;
        to_cnt_d     = to_cnt_q;

        if (i_abort) begin
            // Abort wins over everything; only an error being held is released.
            state_d = S_IDLE;
            if (state_q == S_ERROR) begin
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        sel_d        = i_sel;
                        to_cnt_d     = '0;
                        err_d        = 1'b0;
                        err_code_d   = ERR_NONE;
                        feed_valid_d = 1'b1;
                        state_d      = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_cnt_d = to_cnt_q + TO_BW'(1);
                    state_d  = S_RUN;
                end
                S_RUN: begin
                    to_cnt_d = to_cnt_q + TO_BW'(1);
                    if (i_result_valid) begin
                        // A result on the terminal cycle still counts as a success.
                        alpha_d     = i_alpha;
                        led_d       = i_led;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = S_DONE;
`ifdef CNN_SCHED_COUNT_CHECK_EN
                        if (cnt_mismatch_c) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_COUNT;
                        end
`endif
                    end else if (to_term_c) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = S_ERROR;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_ERROR: begin
                    // A start here only acknowledges the error; it does not launch.
                    if (i_start) begin
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                        state_d    = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_LAUNCH) || (state_d == S_RUN) || (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            feed_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            alpha_q      <= '0;
            led_q        <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            frame_cnt_q  <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            feed_valid_q <= feed_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            alpha_q      <= alpha_d;
            led_q        <= led_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            frame_cnt_q  <= frame_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign o_feed_valid = feed_valid_q;
    assign o_sel        = sel_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_alpha      = alpha_q;
    assign o_led        = led_q;
    assign o_err        = err_q;
    assign o_err_code   = err_code_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Directed bench for cnn_frame_scheduler: a vector table for single-cycle
// behaviour plus hand sequences for full frames, timeout, simultaneity and reset.
module tb_cnn_frame_scheduler;

    localparam int unsigned TO = 600;

`ifdef CNN_SCHED_COUNT_CHECK_EN
    localparam logic       CC      = 1'b1;
    localparam logic [1:0] CC_CODE = 2'b10;
`else
    localparam logic       CC      = 1'b0;
    localparam logic [1:0] CC_CODE = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_start, i_abort, i_core_valid, i_pool_valid, i_result_valid;
    logic [3:0] i_sel;
    logic [7:0] i_alpha;
    logic [2:0] i_led;
    logic       o_feed_valid, o_busy, o_done, o_err;
    logic [3:0] o_sel;
    logic [7:0] o_alpha, o_frame_cnt;
    logic [2:0] o_led;
    logic [1:0] o_err_code;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cnn_frame_scheduler #(
        .CONV_OUT_CNT(576), .POOL_OUT_CNT(144), .TIMEOUT(TO), .CNT_BW(10), .TO_BW(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_sel(i_sel), .i_core_valid(i_core_valid), .i_pool_valid(i_pool_valid),
        .i_result_valid(i_result_valid), .i_alpha(i_alpha), .i_led(i_led),
        .o_feed_valid(o_feed_valid), .o_sel(o_sel), .o_busy(o_busy), .o_done(o_done),
        .o_alpha(o_alpha), .o_led(o_led), .o_err(o_err), .o_err_code(o_err_code),
        .o_frame_cnt(o_frame_cnt)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [3:0]  sel;
        logic        rv;
        logic [7:0]  alpha;
        logic [2:0]  led;
        logic [28:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [28:0] pk(input logic f, input logic b, input logic d,
                                       input logic [3:0] s, input logic [7:0] a,
                                       input logic [2:0] l, input logic e,
                                       input logic [1:0] c, input logic [7:0] fc);
        return {f, b, d, s, a, l, e, c, fc};
    endfunction

    function automatic logic [28:0] outs();
        return {o_feed_valid, o_busy, o_done, o_sel, o_alpha, o_led, o_err, o_err_code, o_frame_cnt};
    endfunction

    task automatic set_vec(input int i, input logic st, input logic ab, input logic [3:0] s,
                           input logic rv, input logic [7:0] a, input logic [2:0] l,
                           input logic [28:0] e);
        vecs[i].start = st; vecs[i].abort = ab; vecs[i].sel = s;
        vecs[i].rv = rv; vecs[i].alpha = a; vecs[i].led = l; vecs[i].exp = e;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_start = 0; i_abort = 0; i_sel = 0; i_core_valid = 0; i_pool_valid = 0;
        i_result_valid = 0; i_alpha = 0; i_led = 0;
    endtask

    // Start a frame and step into RUN; returns whether o_feed_valid pulsed once.
    task automatic launch(input logic [3:0] s, output logic ok);
        i_sel = s; i_start = 1;
        tick();
        ok = (o_feed_valid === 1'b1) && (o_busy === 1'b1);
        i_start = 0;
        tick();
        ok = ok && (o_feed_valid === 1'b0) && (o_busy === 1'b1);
    endtask

    initial begin
        int   cycles;
        int   bad;
        logic ok;
        logic [7:0] exp_fc;

        clear_inputs();
        reset_n = 0;
        tick();
        tick();
        check("reset_state", 32'(outs()), 32'(0));
        reset_n = 1;

        //           idx st ab sel  rv alpha  led     f b d sel  alpha  led  err code    fc
        set_vec(0,  0, 0, 4'h0, 1, 8'hAA, 3'd7, pk(0,0,0,4'h0,8'h00,3'd0,0, 2'b00,   8'd0));
        set_vec(1,  1, 0, 4'h3, 0, 8'h00, 3'd0, pk(1,1,0,4'h3,8'h00,3'd0,0, 2'b00,   8'd0));
        set_vec(2,  0, 0, 4'h9, 0, 8'h00, 3'd0, pk(0,1,0,4'h3,8'h00,3'd0,0, 2'b00,   8'd0));
        set_vec(3,  1, 0, 4'h9, 0, 8'h00, 3'd0, pk(0,1,0,4'h3,8'h00,3'd0,0, 2'b00,   8'd0));
        set_vec(4,  0, 0, 4'h9, 1, 8'h41, 3'd5, pk(0,1,1,4'h3,8'h41,3'd5,CC,CC_CODE, 8'd1));
        set_vec(5,  0, 0, 4'h9, 0, 8'h00, 3'd0, pk(0,0,0,4'h3,8'h41,3'd5,CC,CC_CODE, 8'd1));
        set_vec(6,  1, 0, 4'h2, 0, 8'h00, 3'd0, pk(1,1,0,4'h2,8'h41,3'd5,0, 2'b00,   8'd1));
        set_vec(7,  0, 0, 4'h2, 0, 8'h00, 3'd0, pk(0,1,0,4'h2,8'h41,3'd5,0, 2'b00,   8'd1));
        set_vec(8,  0, 1, 4'h2, 1, 8'h55, 3'd2, pk(0,0,0,4'h2,8'h41,3'd5,0, 2'b00,   8'd1));
        set_vec(9,  0, 0, 4'h2, 1, 8'h66, 3'd3, pk(0,0,0,4'h2,8'h41,3'd5,0, 2'b00,   8'd1));
        set_vec(10, 1, 0, 4'h4, 0, 8'h00, 3'd0, pk(1,1,0,4'h4,8'h41,3'd5,0, 2'b00,   8'd1));
        set_vec(11, 0, 0, 4'h4, 0, 8'h00, 3'd0, pk(0,1,0,4'h4,8'h41,3'd5,0, 2'b00,   8'd1));
        set_vec(12, 0, 0, 4'h4, 1, 8'h42, 3'd1, pk(0,1,1,4'h4,8'h42,3'd1,CC,CC_CODE, 8'd2));
        set_vec(13, 0, 0, 4'h4, 0, 8'h00, 3'd0, pk(0,0,0,4'h4,8'h42,3'd1,CC,CC_CODE, 8'd2));

        for (int i = 0; i < 14; i++) begin
            i_start = vecs[i].start; i_abort = vecs[i].abort; i_sel = vecs[i].sel;
            i_result_valid = vecs[i].rv; i_alpha = vecs[i].alpha; i_led = vecs[i].led;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        clear_inputs();
        exp_fc = 8'd2;

        // Nominal frame with full strobe counts, conv and pool strobes overlapping.
        launch(4'h3, ok);
        check("nominal_launch", 32'(ok), 32'(1));
        bad = 0;
        for (int k = 0; k < 576; k++) begin
            i_core_valid = 1;
            i_pool_valid = (k < 144);
            tick();
            if (o_sel !== 4'h3 || o_busy !== 1'b1 || o_done !== 1'b0 || o_err !== 1'b0) bad++;
        end
        i_core_valid = 0; i_pool_valid = 0;
        check("nominal_run_stable", 32'(bad), 32'(0));
        i_result_valid = 1; i_alpha = 8'h41; i_led = 3'b101;
        tick();
        i_result_valid = 0;
        exp_fc = exp_fc + 8'd1;
        check("nominal_done", 32'(outs()), 32'(pk(0,1,1,4'h3,8'h41,3'd5,0,2'b00,exp_fc)));
        tick();
        check("nominal_after", 32'(outs()), 32'(pk(0,0,0,4'h3,8'h41,3'd5,0,2'b00,exp_fc)));

        // Timeout: error must appear exactly TO cycles after the LAUNCH cycle.
        i_sel = 4'h6; i_start = 1;
        tick();
        i_start = 0;
        check("timeout_launch", 32'(o_feed_valid), 32'(1));
        cycles = 0;
        while (o_err !== 1'b1 && cycles < TO + 20) begin
            tick();
            cycles++;
        end
        check("timeout_latency", 32'(cycles), 32'(TO));
        check("timeout_state", 32'({o_err, o_err_code, o_busy, o_done}), 32'({1'b1, 2'b01, 1'b0, 1'b0}));
        i_start = 1;
        tick();
        i_start = 0;
        check("error_ack", 32'({o_feed_valid, o_busy, o_err, o_err_code}), 32'(0));
        tick();
        check("error_no_launch", 32'({o_feed_valid, o_busy}), 32'(0));

        // Result on the timeout terminal cycle: result wins.
        i_sel = 4'h7; i_start = 1;
        tick();
        i_start = 0;
        repeat (TO - 1) tick();
        check("simul_no_early_err", 32'({o_err, o_busy}), 32'({1'b0, 1'b1}));
        i_result_valid = 1; i_alpha = 8'h5A; i_led = 3'd3;
        tick();
        i_result_valid = 0;
        exp_fc = exp_fc + 8'd1;
        check("simul_done", 32'(outs()), 32'(pk(0,1,1,4'h7,8'h5A,3'd3,CC,CC_CODE,exp_fc)));
        tick();
        check("simul_idle", 32'({o_busy, o_err_code}), 32'({1'b0, CC_CODE}));

`ifdef CNN_SCHED_COUNT_CHECK_EN
        // One conv strobe short: done still pulses, mismatch flagged, result captured.
        launch(4'h1, ok);
        check("mismatch_launch", 32'(ok), 32'(1));
        for (int k = 0; k < 575; k++) begin
            i_core_valid = 1;
            i_pool_valid = (k < 144);
            tick();
        end
        i_core_valid = 0; i_pool_valid = 0;
        i_result_valid = 1; i_alpha = 8'h33; i_led = 3'd6;
        tick();
        i_result_valid = 0;
        exp_fc = exp_fc + 8'd1;
        check("mismatch_done", 32'(outs()), 32'(pk(0,1,1,4'h1,8'h33,3'd6,1,2'b10,exp_fc)));
        tick();
`endif

        // Reset mid-RUN forces every output to zero; a later idle result is ignored.
        launch(4'hC, ok);
        check("reset_launch", 32'(ok), 32'(1));
        reset_n = 0;
        tick();
        check("reset_mid_run", 32'(outs()), 32'(0));
        reset_n = 1;
        i_result_valid = 1; i_alpha = 8'hFF; i_led = 3'd7;
        tick();
        i_result_valid = 0;
        check("idle_result_ignored", 32'(outs()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
